// File: rtl/clock_set_controller.sv
// Two-button clock setting controller: synchronised and debounced buttons drive a
// RUN -> SET_HOUR -> SET_MIN sequencer with seconds tick, auto-repeat and field blink.
module clock_set_controller #(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned DEBOUNCE      = 500000,
  parameter int unsigned BLINK_DIV     = 12500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       sec_enable,
  output logic       inc_min,
  output logic       inc_hour,
  output logic       sec_clear,
  output logic [1:0] mode,
  output logic       blank_hour,
  output logic       blank_min
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned DB_W = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;
  localparam int unsigned TK_W = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int unsigned BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned RP_W = (REP_MAX   > 1) ? $clog2(REP_MAX)   : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_DIV - 1);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_e;

  // Bit 0 is the mode button, bit 1 the increment button.
  logic [1:0]            sync1_q, sync2_q, acc_q, acc_d, acc_prev_q, press_q;
  logic [1:0][DB_W-1:0]  dcnt_q, dcnt_d;
  logic                  mode_ev, inc_ev;

  state_e                state_q, state_d;

  logic [TK_W-1:0]       div_q, div_d;
  logic [BL_W-1:0]       bcnt_q, bcnt_d;
  logic                  phase_q, phase_d;
  logic [RP_W-1:0]       rcnt_q, rcnt_d;
  logic                  ract_q, ract_d, rfirst_q, rfirst_d, rep_pulse;
  logic                  sec_en_d, sec_clr_d, inc_hour_d, inc_min_d, blank_hour_d, blank_min_d;

  assign mode_ev = press_q[0];
  assign inc_ev  = press_q[1] & ~press_q[0];
  assign mode    = state_q;

  always_comb begin
    acc_d  = acc_q;
    dcnt_d = dcnt_q;
    for (int unsigned i = 0; i < 2; i++) begin
      if (sync2_q[i] != acc_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          acc_d[i]  = sync2_q[i];
          dcnt_d[i] = '0;
        end else begin
          dcnt_d[i] = dcnt_q[i] + DB_W'(1);
        end
      end else begin
        dcnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      acc_prev_q <= '0;
      press_q    <= '0;
      dcnt_q     <= '0;
    end else begin
      sync1_q    <= {btn_inc, btn_mode};
      sync2_q    <= sync1_q;
      acc_q      <= acc_d;
      acc_prev_q <= acc_q;
      press_q    <= acc_q & ~acc_prev_q;
      dcnt_q     <= dcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mode_ev) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        default:  state_d = RUN;
      endcase
    end
  end

  always_comb begin
    // Divider only advances while RUN persists, so re-entry always starts at 0.
    div_d    = '0;
    sec_en_d = 1'b0;
    if (state_q == RUN && state_d == RUN) begin
      sec_en_d = (div_q == TK_LAST);
      div_d    = (div_q == TK_LAST) ? '0 : div_q + TK_W'(1);
    end
    sec_clr_d = (state_q == SET_MIN) && mode_ev;

    ract_d    = ract_q;
    rfirst_d  = rfirst_q;
    rcnt_d    = rcnt_q;
    rep_pulse = 1'b0;
    if (mode_ev) begin
      ract_d = 1'b0;
    end else if (inc_ev && state_q != RUN) begin
      rep_pulse = 1'b1;
      ract_d    = 1'b1;
      rfirst_d  = 1'b1;
      rcnt_d    = '0;
    end else if (ract_q && acc_q[1]) begin
      if (rcnt_q == (rfirst_q ? RD_LAST : RP_LAST)) begin
        rep_pulse = 1'b1;
        rfirst_d  = 1'b0;
        rcnt_d    = '0;
      end else begin
        rcnt_d = rcnt_q + RP_W'(1);
      end
    end else begin
      ract_d = 1'b0;
    end
    inc_hour_d = rep_pulse && (state_q == SET_HOUR);
    inc_min_d  = rep_pulse && (state_q == SET_MIN);

    bcnt_d  = '0;
    phase_d = 1'b0;
    if (state_d == state_q && state_d != RUN) begin
      phase_d = phase_q;
      if (bcnt_q == BL_LAST) phase_d = ~phase_q;
      else                   bcnt_d  = bcnt_q + BL_W'(1);
    end
    blank_hour_d = (state_d == SET_HOUR) && phase_d;
    blank_min_d  = (state_d == SET_MIN)  && phase_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      rcnt_q     <= '0;
      ract_q     <= 1'b0;
      rfirst_q   <= 1'b0;
      sec_enable <= 1'b0;
      sec_clear  <= 1'b0;
      inc_hour   <= 1'b0;
      inc_min    <= 1'b0;
      blank_hour <= 1'b0;
      blank_min  <= 1'b0;
    end else begin
      div_q      <= div_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      rcnt_q     <= rcnt_d;
      ract_q     <= ract_d;
      rfirst_q   <= rfirst_d;
      sec_enable <= sec_en_d;
      sec_clear  <= sec_clr_d;
      inc_hour   <= inc_hour_d;
      inc_min    <= inc_min_d;
      blank_hour <= blank_hour_d;
      blank_min  <= blank_min_d;
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: directed scenarios plus random button traffic,
// compared cycle by cycle against a timing-based behavioural model.
module tb_clock_set_controller;

  localparam int unsigned TICK_DIV      = 10;
  localparam int unsigned DEBOUNCE      = 4;
  localparam int unsigned BLINK_DIV     = 6;
  localparam int unsigned REPEAT_DELAY  = 20;
  localparam int unsigned REPEAT_PERIOD = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       sec_enable, inc_min, inc_hour, sec_clear, blank_hour, blank_min;
  logic [1:0] mode;

  int vectors = 0;
  int miscompares = 0;

  clock_set_controller #(
    .TICK_DIV(TICK_DIV),
    .DEBOUNCE(DEBOUNCE),
    .BLINK_DIV(BLINK_DIV),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_inc(btn_inc),
    .sec_enable(sec_enable),
    .inc_min(inc_min),
    .inc_hour(inc_hour),
    .sec_clear(sec_clear),
    .mode(mode),
    .blank_hour(blank_hour),
    .blank_min(blank_min)
  );

  always #5 clk = ~clk;

  // Model: mode index 0..2, age = cycles since entering the current mode,
  // repeat age = cycles since the initial increment pulse.
  int       m_mode, m_age, m_rep_age;
  int       m_streak [2];
  bit       m_pm, m_pi, m_rep_on;
  bit [1:0] m_acc, m_prev, m_sync, m_pend;
  bit       e_sec, e_ih, e_im, e_clr;

  function automatic logic [7:0] dut_vec();
    return {sec_enable, inc_hour, inc_min, sec_clear, mode, blank_hour, blank_min};
  endfunction

  function automatic logic [7:0] exp_vec();
    logic       ph;
    logic [1:0] mc;
    ph = ((m_age / BLINK_DIV) % 2) == 1;
    mc = 2'(m_mode);
    return {e_sec, e_ih, e_im, e_clr, mc, (m_mode == 1) && ph, (m_mode == 2) && ph};
  endfunction

  task automatic model_step();
    bit [1:0] raw;
    bit       pulse;
    int       nxt;
    raw = {btn_inc, btn_mode};
    if (reset) begin
      m_mode = 0; m_age = 0; m_rep_age = 0; m_rep_on = 0;
      m_pm = 0; m_pi = 0; m_acc = '0; m_prev = '0; m_sync = '0; m_pend = '0;
      m_streak[0] = 0; m_streak[1] = 0;
      e_sec = 0; e_ih = 0; e_im = 0; e_clr = 0;
    end else begin
      nxt   = m_pm ? (m_mode + 1) % 3 : m_mode;
      e_clr = m_pm && (m_mode == 2);
      pulse = 0;
      if (m_pm) begin
        m_rep_on = 0;
      end else if (m_pi && m_mode != 0) begin
        pulse = 1; m_rep_on = 1; m_rep_age = 0;
      end else if (m_rep_on && m_acc[1]) begin
        m_rep_age++;
        if (m_rep_age == REPEAT_DELAY ||
            (m_rep_age > REPEAT_DELAY && (m_rep_age - REPEAT_DELAY) % REPEAT_PERIOD == 0))
          pulse = 1;
      end else begin
        m_rep_on = 0;
      end
      e_ih   = pulse && (m_mode == 1);
      e_im   = pulse && (m_mode == 2);
      m_age  = m_pm ? 0 : m_age + 1;
      m_mode = nxt;
      e_sec  = (m_mode == 0) && (m_age > 0) && (m_age % TICK_DIV == 0);
      m_pm   = m_acc[0] && !m_prev[0];
      m_pi   = m_acc[1] && !m_prev[1];
      m_prev = m_acc;
      for (int b = 0; b < 2; b++) begin
        if (m_sync[b] != m_acc[b]) begin
          m_streak[b]++;
          if (m_streak[b] == DEBOUNCE) begin
            m_acc[b] = m_sync[b];
            m_streak[b] = 0;
          end
        end else begin
          m_streak[b] = 0;
        end
      end
      m_sync = m_pend;
      m_pend = raw;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      btn_mode = 1'($urandom_range(0, 1));
      btn_inc  = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL reset_model cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      vectors++;
      if (dut_vec() !== 8'h00) begin
        miscompares++; $display("FAIL reset_zero cyc %0d: got %b want 00000000", c, dut_vec());
      end
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic test_tick();
    int npulse = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL tick cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (sec_enable) npulse++;
    end
    vectors++;
    if (npulse != 3) begin
      miscompares++; $display("FAIL tick_count: got %0d want 3", npulse);
    end
  endtask

  task automatic test_glitch();
    int nset = 0;
    for (int c = 0; c < 12; c++) begin
      btn_mode = (c < 2);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL glitch cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (mode !== 2'b00) begin
      miscompares++; $display("FAIL glitch_mode: got %b want 00", mode);
    end
    for (int c = 0; c < 16; c++) begin
      btn_mode = (c < 8);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL held_mode cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (mode == 2'b01 && sec_enable) nset++;
    end
    vectors++;
    if (mode !== 2'b01 || nset != 0) begin
      miscompares++; $display("FAIL held_mode_end: got mode %b sec %0d want 01 0", mode, nset);
    end
  endtask

  task automatic test_set_min_repeat();
    int offs[$];
    int want[5] = '{0, 20, 25, 30, 35};
    int nh = 0;
    for (int c = 0; c < 16; c++) begin
      btn_mode = (c < 8);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL to_setmin cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (mode !== 2'b10) begin
      miscompares++; $display("FAIL to_setmin_mode: got %b want 10", mode);
    end
    for (int c = 0; c < 60; c++) begin
      btn_inc = (c < 40);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL repeat cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (inc_min) offs.push_back(c);
      if (inc_hour) nh++;
    end
    vectors++;
    if (offs.size() != 5 || nh != 0) begin
      miscompares++; $display("FAIL repeat_count: got %0d min %0d hour want 5 0", offs.size(), nh);
    end
    for (int i = 1; i < offs.size() && i < 5; i++) begin
      vectors++;
      if (offs[i] - offs[0] != want[i]) begin
        miscompares++; $display("FAIL repeat_offset %0d: got %0d want %0d", i, offs[i] - offs[0], want[i]);
      end
    end
  endtask

  task automatic test_exit();
    int nclr = 0, cclr = -100, csec = -1;
    for (int c = 0; c < 30; c++) begin
      btn_mode = (c < 8);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL exit cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (sec_clear) begin nclr++; cclr = c; end
      if (sec_enable && csec < 0) csec = c;
    end
    vectors++;
    if (mode !== 2'b00 || nclr != 1 || csec - cclr != 10) begin
      miscompares++;
      $display("FAIL exit_seq: got mode %b clr %0d gap %0d want 00 1 10", mode, nclr, csec - cclr);
    end
  endtask

  task automatic test_same_cycle();
    int ninc = 0;
    for (int c = 0; c < 16; c++) begin
      btn_mode = (c < 8);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL to_sethour cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    for (int c = 0; c < 30; c++) begin
      btn_mode = (c < 8);
      btn_inc  = (c < 8);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL same_cycle cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (inc_hour || inc_min) ninc++;
    end
    vectors++;
    if (mode !== 2'b10 || ninc != 0) begin
      miscompares++; $display("FAIL same_cycle_end: got mode %b inc %0d want 10 0", mode, ninc);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int nbefore = 0, nafter = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 16; c++) begin
      btn_mode = (c < 8);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL rst_setup cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
    end
    for (int c = 0; c < 80; c++) begin
      btn_inc = (c < 70);
      reset   = (c == 35);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL rst_repeat cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (c == 35) begin
        vectors++;
        if (dut_vec() !== 8'h00) begin
          miscompares++; $display("FAIL rst_repeat_zero: got %b want 00000000", dut_vec());
        end
      end
      if (inc_hour && c < 35) nbefore++;
      if (inc_hour && c > 35) nafter++;
    end
    reset = 1'b0;
    vectors++;
    if (nbefore != 3 || nafter != 0 || mode !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_repeat_end: got %0d/%0d mode %b want 3/0 00", nbefore, nafter, mode);
    end
  endtask

  task automatic test_random();
    int hm = 1, hi = 1, nexcl = 0;
    for (int c = 0; c < 800; c++) begin
      hm = hm - 1;
      if (hm == 0) begin
        btn_mode = 1'($urandom_range(0, 1));
        hm = $urandom_range(1, 12);
      end
      hi = hi - 1;
      if (hi == 0) begin
        btn_inc = 1'($urandom_range(0, 1));
        hi = btn_inc ? $urandom_range(1, 45) : $urandom_range(1, 12);
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++; $display("FAIL random cyc %0d: got %b want %b", c, dut_vec(), exp_vec());
      end
      if (32'(sec_enable) + 32'(inc_hour) + 32'(inc_min) > 1) nexcl++;
    end
    reset    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    vectors++;
    if (nexcl != 0) begin
      miscompares++; $display("FAIL exclusive: got %0d overlaps want 0", nexcl);
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_glitch();
    test_set_min_repeat();
    test_exit();
    test_same_cycle();
    test_reset_mid_repeat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per one-second tick.
REQ-002 Parameter DEBOUNCE, default 500000: consecutive stable cycles required to accept a button level change.
REQ-003 Parameter BLINK_DIV, default 12500000: clk cycles per blink half-period.
REQ-004 Parameter REPEAT_DELAY, default 25000000: held-button cycles before auto-repeat starts.
REQ-005 Parameter REPEAT_PERIOD, default 10000000: cycles between auto-repeat pulses.
REQ-006 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-007 Port reset, input, 1, synchronous, active-high reset.
REQ-008 Port btn_mode, input, 1, raw asynchronous mode button, active-high.
REQ-009 Port btn_inc, input, 1, raw asynchronous increment button, active-high.
REQ-010 Port sec_enable, output, 1, one-cycle enable pulse to the seconds-units counter.
REQ-011 Port inc_min, output, 1, one-cycle increment pulse to the minutes-units counter.
REQ-012 Port inc_hour, output, 1, one-cycle increment pulse to the hours-units counter.
REQ-013 Port sec_clear, output, 1, one-cycle pulse clearing the seconds counters.
REQ-014 Port mode, output, 2, current state: 00 RUN, 01 SET_HOUR, 10 SET_MIN.
REQ-015 Port blank_hour / blank_min, output, 1 each, display-blank request for the field being set.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 Debounce: per button, a counter SHALL increment while synced level != accepted level, clear when equal; accepted level SHALL take the synced level, and the counter clear, on the cycle the counter reaches DEBOUNCE-1.
REQ-018 Press event SHALL be a registered one-cycle pulse the cycle after the accepted level rises 0->1; releases generate no event.
REQ-019 FSM SHALL be RUN -> SET_HOUR -> SET_MIN -> RUN, one transition per mode press event; no other transitions.
REQ-020 On SET_MIN -> RUN, sec_clear SHALL pulse high for exactly the first RUN cycle and the tick divider SHALL restart from 0.
REQ-021 Tick divider SHALL count 0..TICK_DIV-1 only in RUN, wrap to 0, and be held at 0 in set states.
REQ-022 sec_enable SHALL be registered, high for one cycle each time the divider wraps in RUN, never high in set states.
REQ-023 An inc press event SHALL yield a one-cycle inc_hour in SET_HOUR, inc_min in SET_MIN, and nothing in RUN.
REQ-024 Auto-repeat: while inc accepted level stays high in a set state, further pulses SHALL occur REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
REQ-025 Any state change SHALL cancel auto-repeat; pulses resume only on a fresh inc press event.
REQ-026 Mode and inc press events in the same cycle: mode SHALL win, inc event discarded.
REQ-027 inc_hour, inc_min, sec_enable SHALL be mutually exclusive in every cycle.
REQ-028 Blink phase SHALL toggle every BLINK_DIV cycles in set states, reset to 0 (visible) on every state entry; blank_hour = phase in SET_HOUR, blank_min = phase in SET_MIN, both 0 in RUN.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset high at a clk edge SHALL force mode=00, all pulses 0, blank_* 0, all counters, synchronizers, accepted levels and blink phase to 0, overriding all other activity including mid-debounce and mid-repeat.
REQ-031 A button held through reset SHALL be treated as a new press after DEBOUNCE cycles post-reset.

Verification (TICK_DIV=10, DEBOUNCE=4, BLINK_DIV=6, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-032 Reset released, no buttons, 35 cycles -> sec_enable pulses exactly every 10 cycles, mode=00, other outputs 0.
REQ-033 btn_mode glitch high 2 cycles -> no event, mode stays 00; held 8 cycles -> mode 01, sec_enable stops, divider held.
REQ-034 In SET_MIN, btn_inc held 40 cycles -> inc_min at press, +20, +25, +30, +35 cycles; inc_hour never high.
REQ-035 Third mode press from SET_MIN -> mode 00, sec_clear one cycle, first sec_enable 10 cycles later.
REQ-036 Mode and inc accepted in same cycle while in SET_HOUR -> mode 10, no inc_hour/inc_min pulse.
REQ-037 Reset asserted mid auto-repeat in SET_HOUR -> next cycle mode=00, all outputs 0, no further inc_hour.
